// File: rtl/reg_dest_hazard_unit.sv
// Destination-register hazard tracker: shadows EX/MEM/WB destinations, selects
// operand forwarding into EX and raises the load-use stall for PC and IF/ID.
module reg_dest_hazard_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [4:0]       id_dest,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       ex_fwd_a,
  output logic [1:0]       ex_fwd_b,
  output logic [4:0]       wb_dest,
  output logic             wb_write,
  output logic [CNT_W-1:0] stall_count
);

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       wr;
    logic       ld;
  } slot_t;

  localparam slot_t BUBBLE = '{valid: 1'b0, dest: 5'd0, wr: 1'b0, ld: 1'b0};
  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b10;
  localparam logic [1:0] FWD_WB   = 2'b01;

  slot_t ex_slot;
  slot_t mem_slot;
  slot_t wb_slot;

  logic ex_prod;
  logic mem_prod;
  logic haz_a_ex;
  logic haz_b_ex;
  logic haz_a_mem;
  logic haz_b_mem;
  logic load_ex;
  logic [1:0] fwd_a_next;
  logic [1:0] fwd_b_next;

  // Register 0 is hardwired, so a slot targeting it never counts as a producer.
  always_comb begin
    ex_prod   = ex_slot.valid & ex_slot.wr & (ex_slot.dest != 5'd0);
    mem_prod  = mem_slot.valid & mem_slot.wr & (mem_slot.dest != 5'd0);
    haz_a_ex  = id_valid & id_uses_rs & (id_rs == ex_slot.dest) & ex_prod;
    haz_b_ex  = id_valid & id_uses_rt & (id_rt == ex_slot.dest) & ex_prod;
    haz_a_mem = id_valid & id_uses_rs & (id_rs == mem_slot.dest) & mem_prod;
    haz_b_mem = id_valid & id_uses_rt & (id_rt == mem_slot.dest) & mem_prod;
  end

  always_comb begin
    stall      = reset_n & ~flush & ex_slot.ld & (haz_a_ex | haz_b_ex);
    load_ex    = id_valid & ~stall & ~flush;
    fwd_a_next = FWD_NONE;
    fwd_b_next = FWD_NONE;
    if (haz_a_ex)       fwd_a_next = FWD_MEM;
    else if (haz_a_mem) fwd_a_next = FWD_WB;
    if (haz_b_ex)       fwd_b_next = FWD_MEM;
    else if (haz_b_mem) fwd_b_next = FWD_WB;
  end

  // WB-stage producers need no forwarding: the regfile writes before it reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_slot  <= BUBBLE;
      mem_slot <= BUBBLE;
      wb_slot  <= BUBBLE;
      ex_fwd_a <= FWD_NONE;
      ex_fwd_b <= FWD_NONE;
    end else begin
      wb_slot  <= mem_slot;
      mem_slot <= ex_slot;
      if (load_ex) begin
        ex_slot  <= '{valid: 1'b1, dest: id_dest, wr: id_reg_write, ld: id_mem_read};
        ex_fwd_a <= fwd_a_next;
        ex_fwd_b <= fwd_b_next;
      end else begin
        ex_slot  <= BUBBLE;
        ex_fwd_a <= FWD_NONE;
        ex_fwd_b <= FWD_NONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_count <= '0;
    end else if (stall && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign wb_dest  = wb_slot.dest;
  assign wb_write = wb_slot.valid & wb_slot.wr;

endmodule

// File: tb/tb_reg_dest_hazard_unit.sv
// Directed bench for reg_dest_hazard_unit: a 16-bit counter instance and a
// 2-bit counter instance share stimulus so saturation can be observed.
module tb_reg_dest_hazard_unit;

  logic        clk;
  logic        reset_n;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic [4:0]  id_dest;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        flush;
  logic        stall;
  logic [1:0]  ex_fwd_a;
  logic [1:0]  ex_fwd_b;
  logic [4:0]  wb_dest;
  logic        wb_write;
  logic [15:0] stall_count;
  logic        stall_s;
  logic [1:0]  ex_fwd_a_s;
  logic [1:0]  ex_fwd_b_s;
  logic [4:0]  wb_dest_s;
  logic        wb_write_s;
  logic [1:0]  stall_count_s;

  int checks = 0;
  int errors = 0;

  reg_dest_hazard_unit #(.CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .stall(stall), .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b), .wb_dest(wb_dest),
    .wb_write(wb_write), .stall_count(stall_count)
  );

  reg_dest_hazard_unit #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .stall(stall_s), .ex_fwd_a(ex_fwd_a_s), .ex_fwd_b(ex_fwd_b_s), .wb_dest(wb_dest_s),
    .wb_write(wb_write_s), .stall_count(stall_count_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                               input logic urs, input logic urt, input logic [4:0] dest,
                               input logic rw, input logic mr, input logic fl);
    id_valid     = v;
    id_rs        = rs;
    id_rt        = rt;
    id_uses_rs   = urs;
    id_uses_rt   = urt;
    id_dest      = dest;
    id_reg_write = rw;
    id_mem_read  = mr;
    flush        = fl;
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic advanceClock();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    applyStimulus(1'b1, 5'($urandom), 5'($urandom), 1'b1, 1'b1, 5'($urandom),
                  1'b1, 1'b1, 1'b0);
    advanceClock();
    applyStimulus(1'b1, 5'($urandom), 5'($urandom), 1'b1, 1'b1, 5'($urandom),
                  1'b1, 1'b1, 1'b0);
    advanceClock();
    checkOutput("reset_stall", stall, 1'b0);
    checkOutput("reset_fwd_a", ex_fwd_a, 2'b00);
    checkOutput("reset_fwd_b", ex_fwd_b, 2'b00);
    checkOutput("reset_wb_write", wb_write, 1'b0);
    checkOutput("reset_count", stall_count, 16'd0);
    reset_n = 1'b1;

    applyStimulus(1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0);
    advanceClock();
    checkOutput("first_fwd_a", ex_fwd_a, 2'b00);
    checkOutput("first_fwd_b", ex_fwd_b, 2'b00);

    // Back-to-back ALU dependence
    applyStimulus(1'b1, 5'd10, 5'd11, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    advanceClock();
    applyStimulus(1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("alu_dep_stall", stall, 1'b0);
    advanceClock();
    checkOutput("alu_dep_fwd_a", ex_fwd_a, 2'b10);
    checkOutput("alu_dep_fwd_b", ex_fwd_b, 2'b00);

    // Distance-2 dependence on operand B
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
    advanceClock();
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0);
    advanceClock();
    applyStimulus(1'b1, 5'd13, 5'd9, 1'b1, 1'b1, 5'd14, 1'b0, 1'b0, 1'b0);
    advanceClock();
    checkOutput("dist2_fwd_b", ex_fwd_b, 2'b01);
    checkOutput("dist2_fwd_a", ex_fwd_a, 2'b00);

    // Both EX and MEM produce r9; rs==rt so both selects pick the nearer one
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
    advanceClock();
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
    advanceClock();
    applyStimulus(1'b1, 5'd9, 5'd9, 1'b1, 1'b1, 5'd15, 1'b1, 1'b0, 1'b0);
    advanceClock();
    checkOutput("near_fwd_a", ex_fwd_a, 2'b10);
    checkOutput("near_fwd_b", ex_fwd_b, 2'b10);

    // Load-use
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0);
    advanceClock();
    applyStimulus(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("lu_stall", stall, 1'b1);
    advanceClock();
    checkOutput("lu_count", stall_count, 16'd1);
    checkOutput("lu_count_sat", stall_count_s, 2'd1);
    checkOutput("lu_stall_once", stall, 1'b0);
    checkOutput("lu_bubble_fwd_a", ex_fwd_a, 2'b00);
    advanceClock();
    checkOutput("lu_fwd_a", ex_fwd_a, 2'b01);
    checkOutput("lu_wb_dest", wb_dest, 5'd3);
    checkOutput("lu_wb_write", wb_write, 1'b1);

    // A load writing r0 is not a producer
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    advanceClock();
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd16, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("r0_stall", stall, 1'b0);
    advanceClock();
    checkOutput("r0_fwd_a", ex_fwd_a, 2'b00);
    checkOutput("r0_fwd_b", ex_fwd_b, 2'b00);

    // Flush overrides a load-use stall
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0);
    advanceClock();
    applyStimulus(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 5'd17, 1'b1, 1'b0, 1'b1);
    #1;
    checkOutput("flush_stall", stall, 1'b0);
    advanceClock();
    checkOutput("flush_bubble_fwd_a", ex_fwd_a, 2'b00);
    checkOutput("flush_count", stall_count, 16'd1);
    applyStimulus(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 5'd17, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("post_flush_stall", stall, 1'b0);
    advanceClock();
    checkOutput("post_flush_fwd_a", ex_fwd_a, 2'b01);
    checkOutput("post_flush_wb_dest", wb_dest, 5'd4);
    checkOutput("post_flush_wb_write", wb_write, 1'b1);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    advanceClock();
    checkOutput("bubble_wb_write", wb_write, 1'b0);

    // Five more load-use stalls: the 2-bit counter pins at 3
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0);
      advanceClock();
      applyStimulus(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
      advanceClock();
      advanceClock();
    end
    checkOutput("sat_count", stall_count_s, 2'd3);
    checkOutput("wide_count", stall_count, 16'd6);

    // Asynchronous reset in the middle of a load-use stall
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0);
    advanceClock();
    applyStimulus(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("pre_reset_stall", stall, 1'b1);
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("async_stall", stall, 1'b0);
    checkOutput("async_fwd_a", ex_fwd_a, 2'b00);
    checkOutput("async_fwd_b", ex_fwd_b, 2'b00);
    checkOutput("async_wb_write", wb_write, 1'b0);
    checkOutput("async_wb_dest", wb_dest, 5'd0);
    checkOutput("async_count", stall_count, 16'd0);
    checkOutput("async_count_sat", stall_count_s, 2'd0);
    advanceClock();
    reset_n = 1'b1;
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    advanceClock();
    checkOutput("after_reset_stall", stall, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
